// File: rtl/alu_issue.sv
// Decode/issue stage for the 16-bit ALU datapath.
// One-entry registered issue slot, architectural {S,Z,C,V} flag register with
// same-edge forwarding into conditional-branch resolution, and a RUN/HALT FSM.
module alu_issue #(
    parameter logic [3:0] FLAG_RESET = 4'b0000,
    parameter bit         HALT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_op,
    output logic [3:0]  out_alu_d,
    output logic [2:0]  out_rs,
    output logic [2:0]  out_rd,
    output logic        out_src_imm,
    output logic [15:0] out_imm,
    output logic        out_reg_we,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic        out_br_taken,
    output logic [15:0] out_br_target,
    output logic        out_illegal,
    input  logic        alu_s,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic [3:0]  flags,
    output logic        halted,
    input  logic        resume
);

    typedef enum logic {StRun, StHalt} state_t;

    typedef struct packed {
        logic        valid;
        logic        set_flags;  // retiring this entry writes the flag register
        logic [3:0]  alu_op;
        logic [3:0]  alu_d;
        logic [2:0]  rs;
        logic [2:0]  rd;
        logic        src_imm;
        logic [15:0] imm;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        br_taken;
        logic [15:0] br_target;
        logic        illegal;
    } slot_t;

    state_t     state_q, state_d;
    slot_t      slot_q, dec;
    logic [3:0] flags_q;
    logic [3:0] fwd;
    logic       dec_halt;
    logic       capture, retire, flag_upd;
    logic [3:0] op3;
    logic [15:0] sext8;

    assign in_ready = (state_q == StRun) && (!slot_q.valid || out_ready);
    assign capture  = in_valid && in_ready;
    assign retire   = slot_q.valid && out_ready;
    assign flag_upd = retire && slot_q.set_flags;
    // Branches captured on the retiring edge see the ALU flags, not the stale register.
    assign fwd      = flag_upd ? {alu_s, alu_z, alu_c, alu_v} : flags_q;
    assign op3      = in_instr[7:4];
    assign sext8    = {{8{in_instr[7]}}, in_instr[7:0]};

    // Instruction decode into a candidate slot entry.
    always_comb begin
        dec       = '0;
        dec_halt  = 1'b0;
        dec.valid = 1'b1;
        unique case (in_instr[15:14])
            2'b11: begin
                dec.rs    = in_instr[13:11];
                dec.rd    = in_instr[10:8];
                dec.alu_d = in_instr[3:0];
                case (op3)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110,
                    4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                        dec.alu_op    = op3;
                        dec.reg_we    = 1'b1;
                        dec.set_flags = 1'b1;
                    end
                    4'b0101: begin
                        dec.alu_op    = 4'b0001;
                        dec.set_flags = 1'b1;
                    end
                    4'b1111: begin
                        dec.alu_op = 4'b0111;
                        dec_halt   = HALT_EN;
                    end
                    default: begin
                        dec.alu_op  = 4'b0111;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            2'b00, 2'b01: begin
                dec.rd      = in_instr[13:11];
                dec.rs      = in_instr[10:8];
                dec.src_imm = 1'b1;
                dec.imm     = sext8;
                dec.mem_rd  = !in_instr[14];
                dec.reg_we  = !in_instr[14];
                dec.mem_wr  = in_instr[14];
            end
            default: begin
                case (in_instr[13:11])
                    3'b000: begin
                        dec.rd      = in_instr[10:8];
                        dec.alu_op  = 4'b0110;
                        dec.src_imm = 1'b1;
                        dec.imm     = sext8;
                        dec.reg_we  = 1'b1;
                    end
                    3'b100: begin
                        dec.br_taken  = 1'b1;
                        dec.br_target = in_pc + 16'd1 + sext8;
                    end
                    3'b111: begin
                        dec.br_target = in_pc + 16'd1 + sext8;
                        case (in_instr[10:8])
                            3'b000:  dec.br_taken = fwd[2];
                            3'b001:  dec.br_taken = fwd[3] ^ fwd[0];
                            3'b010:  dec.br_taken = fwd[2] | (fwd[3] ^ fwd[0]);
                            3'b011:  dec.br_taken = !fwd[2];
                            default: dec.illegal  = 1'b1;
                        endcase
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
        endcase
    end

    // RUN/HALT next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:  if (capture && dec_halt) state_d = StHalt;
            StHalt: if (resume) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // Issue slot, flag register and FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            flags_q <= FLAG_RESET;
            state_q <= StRun;
        end else begin
            state_q <= state_d;
            if (flag_upd) flags_q <= {alu_s, alu_z, alu_c, alu_v};
            if (capture)     slot_q <= dec;
            else if (retire) slot_q <= '0;
        end
    end

    assign out_valid     = slot_q.valid;
    assign out_alu_op    = slot_q.alu_op;
    assign out_alu_d     = slot_q.alu_d;
    assign out_rs        = slot_q.rs;
    assign out_rd        = slot_q.rd;
    assign out_src_imm   = slot_q.src_imm;
    assign out_imm       = slot_q.imm;
    assign out_reg_we    = slot_q.reg_we;
    assign out_mem_rd    = slot_q.mem_rd;
    assign out_mem_wr    = slot_q.mem_wr;
    assign out_br_taken  = slot_q.br_taken;
    assign out_br_target = slot_q.br_target;
    assign out_illegal   = slot_q.illegal;
    assign flags         = flags_q;
    assign halted        = (state_q == StHalt);

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected slot contents are queued when an
// instruction is accepted and compared when the slot retires.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, resume;
    logic [15:0] in_instr, in_pc;
    logic [3:0]  out_alu_op, out_alu_d, flags, alu_f;
    logic [2:0]  out_rs, out_rd;
    logic        out_src_imm, out_reg_we, out_mem_rd, out_mem_wr, out_br_taken, out_illegal;
    logic [15:0] out_imm, out_br_target;
    logic        halted;

    int n_chk  = 0;
    int n_pass = 0;
    logic [63:0] exp_q[$];

    alu_issue #(.FLAG_RESET(4'b0000), .HALT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_alu_d(out_alu_d), .out_rs(out_rs), .out_rd(out_rd),
        .out_src_imm(out_src_imm), .out_imm(out_imm), .out_reg_we(out_reg_we),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_br_taken(out_br_taken),
        .out_br_target(out_br_target), .out_illegal(out_illegal),
        .alu_s(alu_f[3]), .alu_z(alu_f[2]), .alu_c(alu_f[1]), .alu_v(alu_f[0]),
        .flags(flags), .halted(halted), .resume(resume)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Packed slot image: op,d,rs,rd,src_imm,imm,we,mem_rd,mem_wr,br_taken,target,illegal.
    function automatic logic [63:0] mk(input logic [3:0] op, input logic [3:0] d,
                                       input logic [2:0] rs, input logic [2:0] rd,
                                       input logic si, input logic [15:0] imm,
                                       input logic we, input logic mr, input logic mw,
                                       input logic bt, input logic [15:0] tgt,
                                       input logic ill);
        return {12'd0, op, d, rs, rd, si, imm, we, mr, mw, bt, tgt, ill};
    endfunction

    function automatic logic [63:0] observed();
        return mk(out_alu_op, out_alu_d, out_rs, out_rd, out_src_imm, out_imm, out_reg_we,
                  out_mem_rd, out_mem_wr, out_br_taken, out_br_target, out_illegal);
    endfunction

    // Retire monitor: compare the slot against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_retire", observed(), 64'd0);
            else check("slot", observed(), exp_q.pop_front());
        end
    end

    // Present an instruction (called just after a rising edge), wait for acceptance.
    task automatic send(input logic [15:0] instr, input logic [15:0] pc, input logic [63:0] e);
        int n = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
        else exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] e_add, e_sll, e_ld, e_cmp, e_hlt;

    initial begin
        e_add = mk(4'h0, 4'h0, 3'd1, 3'd2, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
        e_sll = mk(4'h8, 4'h3, 3'd0, 3'd3, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
        e_ld  = mk(4'h0, 4'h0, 3'd3, 3'd2, 1, 16'hFFFE, 1, 1, 0, 0, 16'h0000, 0);
        e_cmp = mk(4'h1, 4'h0, 3'd1, 3'd0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0);
        e_hlt = mk(4'h7, 4'h0, 3'd0, 3'd0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0);

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b0; resume = 1'b0; alu_f = 4'b0000;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_slot", observed(), 64'd0);
        check("rst_flags", {60'd0, flags}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // ADD with Z from the ALU
        alu_f = 4'b0100;
        send(16'hCA00, 16'h0000, e_add);
        step();
        check("flags_add", {60'd0, flags}, 64'h4);

        // SLL by 3
        alu_f = 4'b1000;
        send(16'hC383, 16'h0001, e_sll);
        step();
        check("flags_sll", {60'd0, flags}, 64'h8);

        // LD leaves flags alone
        alu_f = 4'b0011;
        send(16'h13FE, 16'h0002, e_ld);
        step();
        check("flags_ld", {60'd0, flags}, 64'h8);

        // BE captured on the edge CMP retires with Z=1; stale Z=0
        alu_f = 4'b0100;
        send(16'hC850, 16'h000F, e_cmp);
        send(16'hB804, 16'h0010, mk(4'h0, 4'h0, 3'd0, 3'd0, 0, 16'h0, 0, 0, 0, 1, 16'h0015, 0));
        step();
        check("flags_fwd_be", {60'd0, flags}, 64'h4);

        // BNE captured on the edge CMP retires with Z=1; stale Z=0 after ADD
        alu_f = 4'b0000;
        send(16'hCA00, 16'h000E, e_add);
        send(16'hC850, 16'h000F, e_cmp);
        alu_f = 4'b0100;
        send(16'hBB04, 16'h0010, mk(4'h0, 4'h0, 3'd0, 3'd0, 0, 16'h0, 0, 0, 0, 0, 16'h0015, 0));
        step();
        check("flags_fwd_bne", {60'd0, flags}, 64'h4);

        // Illegal arithmetic, illegal cond with wrapping target, B with negative offset
        alu_f = 4'b1111;
        send(16'hC070, 16'h0020, mk(4'h7, 4'h0, 3'd0, 3'd0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 1));
        send(16'hBC04, 16'hFFFF, mk(4'h0, 4'h0, 3'd0, 3'd0, 0, 16'h0, 0, 0, 0, 0, 16'h0004, 1));
        send(16'hA0FE, 16'h0000, mk(4'h0, 4'h0, 3'd0, 3'd0, 0, 16'h0, 0, 0, 0, 1, 16'hFFFF, 0));
        step();
        check("flags_illegal", {60'd0, flags}, 64'h4);

        // Backpressure: slot held, next instruction waits
        out_ready = 1'b0;
        alu_f = 4'b0010;
        send(16'hCA00, 16'h0030, e_add);
        in_valid = 1'b1; in_instr = 16'hC383; in_pc = 16'h0031;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_slot_hold", observed(), e_add);
            check("bp_flags", {60'd0, flags}, 64'h4);
        end
        step();
        out_ready = 1'b1;
        send(16'hC383, 16'h0031, e_sll);
        step();
        check("flags_bp", {60'd0, flags}, 64'h2);

        // HLT and resume
        alu_f = 4'b1111;
        send(16'hC0F0, 16'h0040, e_hlt);
        @(negedge clk);
        check("hlt_halted", {63'd0, halted}, 64'd1);
        check("hlt_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        check("hlt_flags", {60'd0, flags}, 64'h2);
        check("hlt_still", {63'd0, halted}, 64'd1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("resume_halted", {63'd0, halted}, 64'd0);
        check("resume_in_ready", {63'd0, in_ready}, 64'd1);

        // Reset while halted with a held slot
        out_ready = 1'b0;
        send(16'hC0F0, 16'h0041, e_hlt);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mrst_halted", {63'd0, halted}, 64'd0);
        check("mrst_flags", {60'd0, flags}, 64'd0);
        check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Normal operation after reset
        send(16'h13FE, 16'h0000, e_ld);
        step();
        step();
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that drives the 16-bit ALU (opcode, d, operand selects) and consumes its S/Z/C/V flags.
- Decodes one instruction per handshake into a registered one-entry issue slot.
- Holds the architectural flag register and resolves conditional branches against it, with same-cycle flag forwarding.
- Implements a RUN/HALT state machine for HLT.

Parameters:
FLAG_RESET, 4'b0000, reset value of flags {S,Z,C,V}
HALT_EN, 1, 1: HLT enters HALT; 0: HLT decodes as NOP

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction available
in_ready  output  1  stage can accept
in_instr  input  16  instruction word
in_pc  input  16  PC of in_instr
out_valid  output  1  issue slot holds a decoded instruction
out_ready  input  1  downstream accepts the slot
out_alu_op  output  4  ALU opcode
out_alu_d  output  4  shift amount
out_rs  output  3  source register
out_rd  output  3  destination register
out_src_imm  output  1  ALU operand B = out_imm
out_imm  output  16  sign-extended d8
out_reg_we  output  1  register writeback
out_mem_rd  output  1  load
out_mem_wr  output  1  store
out_br_taken  output  1  branch taken
out_br_target  output  16  in_pc+1+sext(d8)
out_illegal  output  1  undefined encoding
alu_s, alu_z, alu_c, alu_v  input  1 each  flags from ALU for the slot's instruction
flags  output  4  {S,Z,C,V} flag register
halted  output  1  state==HALT
resume  input  1  leave HALT

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0 and all out_* = 0.
  - flags=FLAG_RESET, state=RUN, halted=0.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - Capture on in_valid&&in_ready; out_valid=1 from the next cycle, so latency is 1.
  - Slot clears when out_valid&&out_ready with no new capture.
  - Back-to-back capture and retire at full rate.
  - Slot outputs are stable while out_valid&&!out_ready.
- Decode, class by instr[15:14]:
  - 2'b11 arithmetic: rs=[13:11], rd=[10:8], op3=[7:4], d=[3:0].
    - op3 0000..0100, 0110, 1000..1011: alu_op=op3, reg_we=1.
    - op3 0101 CMP: alu_op=0001, reg_we=0.
    - op3 1111 HLT: alu_op=0111, no side effects; state->HALT at the capture edge if HALT_EN.
    - All other op3: alu_op=0111, out_illegal=1, no side effects.
  - 2'b00 LD / 2'b01 ST: rd=[13:11], rs=[10:8], alu_op=0000, src_imm=1, imm=sext([7:0]).
    - LD: mem_rd=1, reg_we=1.
    - ST: mem_wr=1.
  - 2'b10 with [13:11]=000 LI: rd=[10:8], alu_op=0110, src_imm=1, imm=sext([7:0]), reg_we=1.
  - 2'b10 with [13:11]=100 B: br_taken=1.
  - 2'b10 with [13:11]=111 conditional branch, cond=[10:8]:
    - 000 BE: Z.
    - 001 BLT: S^V.
    - 010 BLE: Z|(S^V).
    - 011 BNE: !Z.
    - Other cond values: illegal, not taken.
  - Other 2'b10 sub-ops: illegal.
- Arithmetic and width: out_br_target is computed for every branch, modulo 2^16 (wraps). br_taken=0 for non-branches.
- Flag update:
  - On out_valid&&out_ready, if the slot instruction is arithmetic-class non-illegal, non-HLT: flags <= {alu_s,alu_z,alu_c,alu_v}.
  - LD/ST/LI/branches leave flags unchanged.
- Forwarding: if a flag update and a conditional-branch capture occur on the same edge, the condition uses the incoming alu_* flags, not the stale register.
- HALT state:
  - in_ready=0; the slot still drains normally.
  - resume=1 in HALT -> RUN on the next edge.
  - resume in RUN is ignored.
- Reset mid-operation: the slot is dropped, flags are restored to FLAG_RESET, and any HALT is exited.

Test Plan:
- ADD: in_instr=16'hCA00 -> next cycle out_valid=1, alu_op=0000, rs=1, rd=2, reg_we=1. Accept with alu_z=1, others 0 -> flags=4'b0100.
- SLL: in_instr=16'hC383 -> alu_op=1000, alu_d=3, rd=3, reg_we=1, src_imm=0.
- LD: in_instr=16'h13FE -> mem_rd=1, reg_we=1, alu_op=0000, src_imm=1, imm=16'hFFFE, rd=2, rs=3.
- Forwarding: CMP 16'hC850 retiring with alu_z=1 on the same edge BE 16'hB804 at in_pc=16'h0010 is captured -> br_taken=1, br_target=16'h0015, flags=4'b0100. BNE under the same conditions -> br_taken=0.
- Backpressure: out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, slot outputs and flags unchanged, in_instr not captured until out_ready=1.
- HLT: in_instr=16'hC0F0 -> halted=1 next cycle, in_ready=0. Pulse resume -> halted=0, in_ready=1 on the next cycle. rst_n low while halted -> halted=0 immediately, flags=FLAG_RESET.
